timer_apb_sequencer: RTL
========================

Name: timer_apb_sequencer

Overview:
APB master that configures and sequences one timer_counter_8bit instance on behalf of a simple command interface. Each command (START, PAUSE, RESUME, STOP) expands into the APB writes the timer needs: TDR load value, then TCR load, then TCR enable. The block sits between a host/test thread and the timer's APB slave port, and tracks the timer's run state. A pair of these blocks lets two timers sharing one prescaler be driven independently.

Parameters:
ADDR_WIDTH, 3, APB address width
DATA_WIDTH, 8, APB data width
TDR_ADDR, 3'b010, timer data register address
TCR_ADDR, 3'b011, timer control register address
TIMEOUT, 16, maximum ACCESS cycles waiting for pready before abort

Ports:
pclk  in  1  system/APB clock
preset_n  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&&cmd_ready at a pclk edge
cmd_op  in  2  0=START 1=PAUSE 2=RESUME 3=STOP
cmd_data  in  DATA_WIDTH  load value (START only)
cmd_down  in  1  count direction, 1=down (START only)
cmd_cks  in  2  clock select, 0..3 = clk_in[0..3] (START only)
cmd_done  out  1  one-cycle pulse: command finished
cmd_err  out  1  one-cycle pulse with cmd_done: command failed/illegal
err_sticky  out  1  set on any pslverr/timeout, cleared only by reset
run_state  out  2  0=STOPPED 1=RUNNING 2=PAUSED
psel, penable, pwrite  out  1 each  APB master controls
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
prdata  in  DATA_WIDTH  unused (reserved for readback)
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset (preset_n=0 at posedge pclk): all outputs 0 except cmd_ready=1 on the following cycle; run_state=STOPPED; latched cfg={down,cks}=0. Reset mid-transfer drops psel/penable at that edge; the transfer is not completed.
- On accept, latch op, data, and cfg (cfg latched on START only; PAUSE/RESUME reuse the latched cfg). TCR byte: bit7 LOAD, bit5 DOWN, bit4 EN, bits[1:0] CKS.
- Transfer lists:
  - START: (TDR,data), (TCR,LOAD|cfg), (TCR,EN|cfg).
  - PAUSE: (TCR,cfg).
  - RESUME: (TCR,EN|cfg).
  - STOP: (TCR,0x00).
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE -> SETUP on accept of a legal op.
  - SETUP: psel=1, penable=0, pwrite=1, paddr/pwdata valid. Lasts 1 cycle, then -> ACCESS.
  - ACCESS: penable=1; paddr/pwdata held stable. On pready=1, sample pslverr:
    - pslverr=0 and more transfers remain -> SETUP of next transfer (back-to-back, psel stays 1).
    - pslverr=0 and last transfer -> DONE.
    - pslverr=1 -> DONE with error; remaining transfers are not issued.
  - Timeout: counter of ACCESS cycles with pready=0; reaching TIMEOUT -> DONE with error, psel=0.
  - DONE: 1 cycle; cmd_done=1, cmd_err per result; psel=0; -> IDLE.
- Legality:
  - START is legal in any run_state.
  - PAUSE is legal only in RUNNING; RESUME only in PAUSED; STOP is always legal.
  - An illegal op is accepted, goes IDLE -> DONE directly with cmd_err=1, and issues no APB activity.
- run_state updates in DONE, only on success: START/RESUME -> RUNNING, PAUSE -> PAUSED, STOP -> STOPPED. On error it is unchanged.
- Latency with pready tied 1, accept at edge N:
  - START: SETUP/ACCESS at cycles N+1..N+6; cmd_done at N+7; cmd_ready at N+8.
  - Single-transfer op: cmd_done at N+3.
- Any pslverr or timeout sets err_sticky.

Decomposition:
- Package timer_ctrl_pkg: op codes, run_state encodings, TCR bit positions (LOAD=7, DOWN=5, EN=4, CKS=1:0), default register addresses.
- One sub-module, apb_write_master: single-transfer SETUP/ACCESS/timeout engine with start/busy/ok/err handshake. The sequencer FSM iterates the transfer list over it.

Test Plan:
- START data=0x5A down=0 cks=01, pready=1 -> writes (2,0x5A),(3,0x81),(3,0x11), each SETUP then ACCESS; cmd_done at accept+7, cmd_err=0; run_state=RUNNING.
- After START, PAUSE with pready low for 3 ACCESS cycles -> single write (3,0x01); ACCESS held 4 cycles with paddr/pwdata stable; run_state=PAUSED. Then RESUME -> write (3,0x11); run_state=RUNNING.
- START with pslverr=1 on the 2nd transfer -> third write never issued; cmd_done+cmd_err pulse; err_sticky=1; run_state stays STOPPED.
- pready stuck 0 on STOP -> abort after exactly 16 ACCESS cycles; psel=0; cmd_err=1; run_state unchanged.
- PAUSE issued in STOPPED -> zero APB cycles; cmd_done+cmd_err at accept+1. STOP from RUNNING -> write (3,0x00); run_state=STOPPED.
- preset_n=0 during the ACCESS of START's 2nd transfer -> next cycle psel=penable=0, run_state=STOPPED, err_sticky=0, cmd_ready=1.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer control path: command codes, run states,
// TCR bit layout and the per-command APB transfer list.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_START  = 2'd0,
    OP_PAUSE  = 2'd1,
    OP_RESUME = 2'd2,
    OP_STOP   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    RS_STOPPED = 2'd0,
    RS_RUNNING = 2'd1,
    RS_PAUSED  = 2'd2
  } run_e;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } phase_e;

  typedef struct packed {
    logic       down;
    logic [1:0] cks;
  } cfg_t;

  localparam int TCR_LOAD_BIT = 7;
  localparam int TCR_DOWN_BIT = 5;
  localparam int TCR_EN_BIT   = 4;
  localparam int TCR_CKS_LSB  = 0;

  localparam logic [2:0] DEF_TDR_ADDR = 3'b010;
  localparam logic [2:0] DEF_TCR_ADDR = 3'b011;

  function automatic logic [7:0] tcr_byte(input logic load, input logic en, input cfg_t cfg);
    logic [7:0] b;
    b = 8'h00;
    b[TCR_LOAD_BIT] = load;
    b[TCR_DOWN_BIT] = cfg.down;
    b[TCR_EN_BIT]   = en;
    b[TCR_CKS_LSB +: 2] = cfg.cks;
    return b;
  endfunction

  // Index of the final transfer in a command's list.
  function automatic logic [1:0] xfer_last(input op_e op);
    return (op == OP_START) ? 2'd2 : 2'd0;
  endfunction

  function automatic logic xfer_is_tdr(input op_e op, input logic [1:0] idx);
    return (op == OP_START) && (idx == 2'd0);
  endfunction

  function automatic logic [7:0] xfer_byte(input op_e op, input logic [1:0] idx,
                                           input logic [7:0] data, input cfg_t cfg);
    logic [7:0] b;
    b = 8'h00;
    case (op)
      OP_START: begin
        if (idx == 2'd0)      b = data;
        else if (idx == 2'd1) b = tcr_byte(1'b1, 1'b0, cfg);
        else                  b = tcr_byte(1'b0, 1'b1, cfg);
      end
      OP_PAUSE:  b = tcr_byte(1'b0, 1'b0, cfg);
      OP_RESUME: b = tcr_byte(1'b0, 1'b1, cfg);
      OP_STOP:   b = 8'h00;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic op_legal(input op_e op, input run_e rs);
    logic ok;
    ok = 1'b0;
    if (op == OP_START || op == OP_STOP) ok = 1'b1;
    else if (op == OP_PAUSE)             ok = (rs == RS_RUNNING);
    else if (op == OP_RESUME)            ok = (rs == RS_PAUSED);
    return ok;
  endfunction

  function automatic run_e run_after(input op_e op);
    run_e r;
    case (op)
      OP_START, OP_RESUME: r = RS_RUNNING;
      OP_PAUSE:            r = RS_PAUSED;
      default:             r = RS_STOPPED;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/apb_write_master.sv
// Single APB write engine: one SETUP cycle, then ACCESS until pready or timeout.
// A start pulse in the completing ACCESS cycle chains the next transfer back-to-back.
module apb_write_master
  import timer_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  ok,
  output logic                  err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  phase_e                phase_q, phase_d;
  logic [CW-1:0]         wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      phase_q <= phase_d;
      wait_q  <= wait_d;
      if (start) begin
        addr_q <= addr;
        data_q <= wdata;
      end
    end
  end

  // The wait counter only advances on stalled ACCESS cycles; the TIMEOUT-th stall aborts.
  always_comb begin
    phase_d = phase_q;
    wait_d  = wait_q;
    ok      = 1'b0;
    err     = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        wait_d = '0;
        if (start) phase_d = PH_SETUP;
      end
      PH_SETUP: begin
        wait_d  = '0;
        phase_d = PH_ACCESS;
      end
      PH_ACCESS: begin
        if (pready) begin
          ok      = !pslverr;
          err     = pslverr;
          phase_d = (start && !pslverr) ? PH_SETUP : PH_IDLE;
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          err     = 1'b1;
          phase_d = PH_IDLE;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  assign busy    = (phase_q != PH_IDLE);
  assign psel    = (phase_q != PH_IDLE);
  assign penable = (phase_q == PH_ACCESS);
  assign pwrite  = (phase_q != PH_IDLE);
  assign paddr   = addr_q;
  assign pwdata  = data_q;

endmodule

// File: rtl/timer_apb_sequencer.sv
// Expands START/PAUSE/RESUME/STOP commands into timer TDR/TCR APB writes
// and tracks the timer's run state.
module timer_apb_sequencer
  import timer_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 3,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] TDR_ADDR   = ADDR_WIDTH'(DEF_TDR_ADDR),
  parameter logic [ADDR_WIDTH-1:0] TCR_ADDR   = ADDR_WIDTH'(DEF_TCR_ADDR),
  parameter int                    TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_down,
  input  logic [1:0]            cmd_cks,
  output logic                  cmd_done,
  output logic                  cmd_err,
  output logic                  err_sticky,
  output logic [1:0]            run_state,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [DATA_WIDTH-1:0] data_q;
  cfg_t                  cfg_q;
  logic [1:0]            idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  sticky_q, set_sticky;
  run_e                  run_q;

  logic                  m_start, m_busy, m_ok, m_err;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;

  op_e                   op_in, x_op;
  cfg_t                  cfg_in, x_cfg;
  logic [1:0]            x_idx;
  logic [DATA_WIDTH-1:0] x_data;
  logic                  accept, legal_in;

  logic                  unused_prdata;
  assign unused_prdata = ^prdata;

  assign op_in    = op_e'(cmd_op);
  assign cfg_in   = (op_in == OP_START) ? cfg_t'({cmd_down, cmd_cks}) : cfg_q;
  assign legal_in = op_legal(op_in, run_q);
  assign accept   = cmd_valid && cmd_ready;

  // In IDLE the first transfer comes straight from the command inputs so SETUP
  // starts the cycle after accept; afterwards the latched command drives the list.
  always_comb begin
    if (state_q == ST_IDLE) begin
      x_op   = op_in;
      x_idx  = 2'd0;
      x_data = cmd_data;
      x_cfg  = cfg_in;
    end else begin
      x_op   = op_q;
      x_idx  = idx_q + 2'd1;
      x_data = data_q;
      x_cfg  = cfg_q;
    end
  end

  assign m_addr  = xfer_is_tdr(x_op, x_idx) ? TDR_ADDR : TCR_ADDR;
  assign m_wdata = DATA_WIDTH'(xfer_byte(x_op, x_idx, 8'(x_data), x_cfg));

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_START;
      data_q   <= '0;
      cfg_q    <= '0;
      idx_q    <= 2'd0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      run_q    <= RS_STOPPED;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      if (accept) begin
        op_q   <= op_in;
        data_q <= cmd_data;
        cfg_q  <= cfg_in;
      end
      if (set_sticky) sticky_q <= 1'b1;
      if (state_q == ST_DONE && !err_q) run_q <= run_after(op_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    m_start    = 1'b0;
    set_sticky = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idx_d = 2'd0;
          if (legal_in) begin
            m_start = 1'b1;
            err_d   = 1'b0;
            state_d = ST_SETUP;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (m_err) begin
          err_d      = 1'b1;
          set_sticky = 1'b1;
          state_d    = ST_DONE;
        end else if (m_ok) begin
          if (idx_q == xfer_last(op_q)) begin
            state_d = ST_DONE;
          end else begin
            m_start = 1'b1;
            idx_d   = idx_q + 2'd1;
            state_d = ST_SETUP;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  apb_write_master #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) u_master (
    .clk    (pclk),
    .rst_n  (preset_n),
    .start  (m_start),
    .addr   (m_addr),
    .wdata  (m_wdata),
    .busy   (m_busy),
    .ok     (m_ok),
    .err    (m_err),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .pready (pready),
    .pslverr(pslverr)
  );

  assign cmd_ready  = (state_q == ST_IDLE) && !m_busy;
  assign cmd_done   = (state_q == ST_DONE);
  assign cmd_err    = (state_q == ST_DONE) && err_q;
  assign err_sticky = sticky_q;
  assign run_state  = run_q;

endmodule
